// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types and helpers for the unified-memory arbiter (mem_arbiter) and
// its tie-break sub-module (mem_arb_grant).
//   - arb_state_t : arbiter FSM state encoding (ARB_IDLE/ARB_IF/ARB_D)
//   - arb_gnt_t   : grant identifier (ARB_GNT_IF / ARB_GNT_D)
//   - port_eligible() : request qualification shared by both ports
// Optional feature macro used by the files that import this package:
//   MEM_ARB_RR_EN - round-robin tie-break instead of fixed D-over-IF priority.
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ARB_STATE_WIDTH = 2;

    typedef enum logic [ARB_STATE_WIDTH-1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_GNT_IF = 1'b0,
        ARB_GNT_D  = 1'b1
    } arb_gnt_t;

    // A port may be granted only when it is asking, is not already being
    // answered this cycle (its valid pulse means the request it holds is the
    // finished one), and is not blocked by an external condition.
    function automatic logic port_eligible(
        input logic req,
        input logic valid,
        input logic block
    );
        return req & ~valid & ~block;
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Purely combinational tie-break between the fetch (IF) and load/store (D)
// ports of the memory arbiter.
// Ports:
//   if_elig   in  : IF port is eligible for a grant this cycle
//   d_elig    in  : D port is eligible for a grant this cycle
//   last_gnt  in  : port granted most recently (only with MEM_ARB_RR_EN)
//   gnt_id    out : winning port
//   gnt_valid out : at least one port is eligible; gnt_id is meaningful
// Macro MEM_ARB_RR_EN: when defined a tie goes to the port not granted last;
// otherwise D always wins a tie and no last-grant input exists.
// -----------------------------------------------------------------------------
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic     if_elig,
    input  logic     d_elig,
`ifdef MEM_ARB_RR_EN
    input  arb_gnt_t last_gnt,
`endif
    output arb_gnt_t gnt_id,
    output logic     gnt_valid
);

    // Pick the winner; a lone eligible port always wins outright.
    always_comb begin
        gnt_id    = ARB_GNT_IF;
        gnt_valid = if_elig | d_elig;
        if (if_elig && d_elig) begin
`ifdef MEM_ARB_RR_EN
            gnt_id = (last_gnt == ARB_GNT_IF) ? ARB_GNT_D : ARB_GNT_IF;
`else
            gnt_id = ARB_GNT_D;
`endif
        end else if (d_elig) begin
            gnt_id = ARB_GNT_D;
        end else begin
            gnt_id = ARB_GNT_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port unified instruction/data memory between the fetch
// stage (IF port) and the load/store stage (D port). One access is in flight
// at a time; the memory side uses a registered request held until ack.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   if_req/if_addr        : fetch request, held until if_valid
//   if_flush              : squashes an in-flight fetch, blocks new IF grants
//   if_rdata/if_valid     : registered fetch result, one-cycle valid pulse
//   if_stall              : if_req & ~if_valid (combinational)
//   d_req/d_we/d_addr/d_wdata : load/store request, held until d_valid
//   d_rdata/d_valid       : registered load data, one-cycle completion pulse
//   d_stall               : d_req & ~d_valid (combinational)
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_rdata/mem_ack     : memory read data and completion
// Macro MEM_ARB_RR_EN: round-robin tie-break with a last-grant register.
// Default (undefined): fixed priority, D wins ties, no last-grant register.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_flush,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    output logic                  if_stall,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    // ------------------------------------------------------------------
    // State and register declarations
    // ------------------------------------------------------------------
    arb_state_t            state_r;
    arb_state_t            state_nxt_s;

    logic                  mem_req_r;
    logic                  mem_req_nxt_s;
    logic                  mem_we_r;
    logic                  mem_we_nxt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0] mem_wdata_r;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt_s;

    logic [DATA_WIDTH-1:0] if_rdata_r;
    logic [DATA_WIDTH-1:0] if_rdata_nxt_s;
    logic                  if_valid_r;
    logic                  if_valid_nxt_s;
    logic [DATA_WIDTH-1:0] d_rdata_r;
    logic [DATA_WIDTH-1:0] d_rdata_nxt_s;
    logic                  d_valid_r;
    logic                  d_valid_nxt_s;

    // drop remembers that the fetch in flight was flushed, so its data is
    // discarded even if if_flush has already fallen by the ack cycle.
    logic                  drop_r;
    logic                  drop_nxt_s;

    logic                  if_elig_s;
    logic                  d_elig_s;
    arb_gnt_t              gnt_id_s;
    logic                  gnt_valid_s;

`ifdef MEM_ARB_RR_EN
    arb_gnt_t              last_gnt_r;
    arb_gnt_t              last_gnt_nxt_s;
`endif

    // ------------------------------------------------------------------
    // Eligibility and tie-break
    // ------------------------------------------------------------------
    assign if_elig_s = port_eligible(if_req, if_valid_r, if_flush);
    assign d_elig_s  = port_eligible(d_req, d_valid_r, 1'b0);

    mem_arb_grant u_grant (
        .if_elig   (if_elig_s),
        .d_elig    (d_elig_s),
`ifdef MEM_ARB_RR_EN
        .last_gnt  (last_gnt_r),
`endif
        .gnt_id    (gnt_id_s),
        .gnt_valid (gnt_valid_s)
    );

    // ------------------------------------------------------------------
    // Next-state and next-register logic
    // ------------------------------------------------------------------
    // FSM transitions plus the next value of every datapath register.
    always_comb begin
        state_nxt_s     = state_r;
        mem_req_nxt_s   = mem_req_r;
        mem_we_nxt_s    = mem_we_r;
        mem_addr_nxt_s  = mem_addr_r;
        mem_wdata_nxt_s = mem_wdata_r;
        if_rdata_nxt_s  = if_rdata_r;
        d_rdata_nxt_s   = d_rdata_r;
        if_valid_nxt_s  = 1'b0;
        d_valid_nxt_s   = 1'b0;
        drop_nxt_s      = drop_r;
`ifdef MEM_ARB_RR_EN
        last_gnt_nxt_s  = last_gnt_r;
`endif

        case (state_r)
            ARB_IDLE: begin
                if (gnt_valid_s) begin
                    mem_req_nxt_s = 1'b1;
                    drop_nxt_s    = 1'b0;
`ifdef MEM_ARB_RR_EN
                    last_gnt_nxt_s = gnt_id_s;
`endif
                    if (gnt_id_s == ARB_GNT_D) begin
                        state_nxt_s     = ARB_D;
                        mem_we_nxt_s    = d_we;
                        mem_addr_nxt_s  = d_addr;
                        mem_wdata_nxt_s = d_wdata;
                    end else begin
                        // Fetches never write; keep wdata where it was.
                        state_nxt_s     = ARB_IF;
                        mem_we_nxt_s    = 1'b0;
                        mem_addr_nxt_s  = if_addr;
                        mem_wdata_nxt_s = mem_wdata_r;
                    end
                end else begin
                    state_nxt_s   = ARB_IDLE;
                    mem_req_nxt_s = 1'b0;
                end
            end

            ARB_IF: begin
                if (mem_ack) begin
                    state_nxt_s   = ARB_IDLE;
                    mem_req_nxt_s = 1'b0;
                    // A flush in the ack cycle itself squashes too.
                    if (drop_r || if_flush) begin
                        drop_nxt_s     = 1'b0;
                        if_valid_nxt_s = 1'b0;
                    end else begin
                        if_rdata_nxt_s = mem_rdata;
                        if_valid_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = ARB_IF;
                    if (if_flush) begin
                        drop_nxt_s = 1'b1;
                    end else begin
                        drop_nxt_s = drop_r;
                    end
                end
            end

            ARB_D: begin
                if (mem_ack) begin
                    state_nxt_s   = ARB_IDLE;
                    mem_req_nxt_s = 1'b0;
                    d_valid_nxt_s = 1'b1;
                    // Stores complete without touching the load data.
                    if (!mem_we_r) begin
                        d_rdata_nxt_s = mem_rdata;
                    end else begin
                        d_rdata_nxt_s = d_rdata_r;
                    end
                end else begin
                    state_nxt_s = ARB_D;
                end
            end

            default: begin
                state_nxt_s   = ARB_IDLE;
                mem_req_nxt_s = 1'b0;
                drop_nxt_s    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ARB_IDLE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_WIDTH{1'b0}};
            mem_wdata_r <= {DATA_WIDTH{1'b0}};
            if_rdata_r  <= {DATA_WIDTH{1'b0}};
            if_valid_r  <= 1'b0;
            d_rdata_r   <= {DATA_WIDTH{1'b0}};
            d_valid_r   <= 1'b0;
            drop_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            mem_req_r   <= mem_req_nxt_s;
            mem_we_r    <= mem_we_nxt_s;
            mem_addr_r  <= mem_addr_nxt_s;
            mem_wdata_r <= mem_wdata_nxt_s;
            if_rdata_r  <= if_rdata_nxt_s;
            if_valid_r  <= if_valid_nxt_s;
            d_rdata_r   <= d_rdata_nxt_s;
            d_valid_r   <= d_valid_nxt_s;
            drop_r      <= drop_nxt_s;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last-grant register; IF after reset so D wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_r <= ARB_GNT_IF;
        end else begin
            last_gnt_r <= last_gnt_nxt_s;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign if_valid  = if_valid_r;
    assign d_rdata   = d_rdata_r;
    assign d_valid   = d_valid_r;

    // Stalls follow the live request so a requester sees the stall in the
    // same cycle it raises req.
    assign if_stall  = if_req & ~if_valid_r;
    assign d_stall   = d_req & ~d_valid_r;

endmodule
